// File: rtl/ysyx_25060170_lsu_stage.sv
`default_nettype none
// ============================================================================
//  Module      : ysyx_25060170_lsu_stage
//  Description : Memory-access stage between EXU and WBU. Issues one
//                load/store at a time over a req/rsp data-memory port,
//                extends load data and hands a registered result bundle
//                to WBU. Non-memory instructions pass through in one cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module ysyx_25060170_lsu_stage #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   // EXU side
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] pc_i,
   input  logic [DATA_W-1:0] inst_i,
   input  logic [DATA_W-1:0] exu_res_i,
   input  logic [DATA_W-1:0] st_data_i,
   input  logic [4:0]        mem_ctl_i,
   input  logic [1:0]        wb_ctl_i,
   input  logic              rd_ena_i,
   input  logic [4:0]        rd_addr_i,
   // data-memory port
   output logic              dm_req_valid,
   input  logic              dm_req_ready,
   output logic [DATA_W-1:0] dm_addr,
   output logic              dm_wen,
   output logic [DATA_W-1:0] dm_wdata,
   output logic [3:0]        dm_wstrb,
   input  logic              dm_rsp_valid,
   input  logic [DATA_W-1:0] dm_rdata,
   // WBU side
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] pc_o,
   output logic [DATA_W-1:0] inst_o,
   output logic [DATA_W-1:0] exu_res_o,
   output logic [1:0]        wb_ctl_o,
   output logic              rd_ena_o,
   output logic [4:0]        rd_addr_o,
   output logic [DATA_W-1:0] ls_rd_data,
   output logic              ls_busy,
   output logic              ls_misalign
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t            r_state;
   logic              r_out_valid;
   logic              r_req_valid;
   logic              r_busy;
   logic              r_misalign;
   logic              r_is_load;
   logic [2:0]        r_funct3;
   logic [DATA_W-1:0] r_pc;
   logic [DATA_W-1:0] r_inst;
   logic [DATA_W-1:0] r_exu_res;
   logic [1:0]        r_wb_ctl;
   logic              r_rd_ena;
   logic [4:0]        r_rd_addr;
   logic [DATA_W-1:0] r_ls_rd_data;
   logic              r_dm_wen;
   logic [DATA_W-1:0] r_dm_wdata;
   logic [3:0]        r_dm_wstrb;

   logic              w_is_load;
   logic              w_is_store;
   logic              w_is_mem;
   logic [1:0]        w_off;
   logic [2:0]        w_f3;
   logic              w_bad_f3;
   logic              w_misalign;
   logic              w_fault;
   logic              w_go_bus;
   logic [3:0]        w_wstrb;
   logic [DATA_W-1:0] w_wdata;
   logic [DATA_W-1:0] w_lane;
   logic [DATA_W-1:0] w_ld_data;
   logic              w_in_fire;
   logic              w_out_fire;

   // Exactly one of load/store set marks a memory op; both or neither is pass-through.
   assign w_is_load  = mem_ctl_i[4] & ~mem_ctl_i[3];
   assign w_is_store = mem_ctl_i[3] & ~mem_ctl_i[4];
   assign w_is_mem   = w_is_load | w_is_store;
   assign w_off      = exu_res_i[1:0];
   assign w_f3       = mem_ctl_i[2:0];

   assign w_out_fire = r_out_valid & out_ready;
   assign in_ready   = ((r_state == S_IDLE) & ~r_out_valid) | w_out_fire;
   assign w_in_fire  = in_valid & in_ready;

   // Classify the incoming access: illegal funct3, misalignment and byte-lane strobes.
   always_comb begin
      w_bad_f3   = 1'b0;
      w_misalign = 1'b0;
      w_wstrb    = 4'b1111;
      if (w_is_load) begin
         w_bad_f3 = (w_f3 == 3'b011) | (w_f3 == 3'b110) | (w_f3 == 3'b111);
      end else begin
         w_bad_f3 = w_f3[2] | (w_f3[1:0] == 2'b11);
      end
      case (w_f3[1:0])
         2'b00:   w_wstrb = 4'b0001 << w_off;
         2'b01: begin
            w_wstrb    = 4'b0011 << w_off;
            w_misalign = w_off[0];
         end
         default: begin
            w_wstrb    = 4'b1111;
            w_misalign = (w_off != 2'b00);
         end
      endcase
   end

   assign w_fault  = w_is_mem & (w_bad_f3 | w_misalign);
   assign w_go_bus = w_is_mem & ~w_fault;
   assign w_wdata  = st_data_i << {w_off, 3'b000};

   // Pick the addressed lane out of the returned word and extend it by access type.
   always_comb begin
      w_lane    = dm_rdata >> {r_exu_res[1:0], 3'b000};
      w_ld_data = w_lane;
      case (r_funct3)
         3'b000:  w_ld_data = {{(DATA_W-8){w_lane[7]}},   w_lane[7:0]};
         3'b001:  w_ld_data = {{(DATA_W-16){w_lane[15]}}, w_lane[15:0]};
         3'b100:  w_ld_data = {{(DATA_W-8){1'b0}},        w_lane[7:0]};
         3'b101:  w_ld_data = {{(DATA_W-16){1'b0}},       w_lane[15:0]};
         default: w_ld_data = w_lane;
      endcase
   end

   // Stage FSM with registered bundle, bus request and status outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state      <= S_IDLE;
         r_out_valid  <= 1'b0;
         r_req_valid  <= 1'b0;
         r_busy       <= 1'b0;
         r_misalign   <= 1'b0;
         r_is_load    <= 1'b0;
         r_funct3     <= 3'b000;
         r_pc         <= '0;
         r_inst       <= '0;
         r_exu_res    <= '0;
         r_wb_ctl     <= 2'b00;
         r_rd_ena     <= 1'b0;
         r_rd_addr    <= 5'd0;
         r_ls_rd_data <= '0;
         r_dm_wen     <= 1'b0;
         r_dm_wdata   <= '0;
         r_dm_wstrb   <= 4'b0000;
      end else begin
         case (r_state)
            S_REQ: begin
               // A response arriving before the request is accepted is ignored.
               if (dm_req_ready) begin
                  r_state     <= S_WAIT;
                  r_req_valid <= 1'b0;
               end
            end
            S_WAIT: begin
               if (dm_rsp_valid) begin
                  r_state     <= S_DONE;
                  r_busy      <= 1'b0;
                  r_out_valid <= 1'b1;
                  if (r_is_load) begin
                     r_ls_rd_data <= w_ld_data;
                  end
               end
            end
            default: ;
         endcase

         if (w_out_fire) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
         end

         // New instruction may be latched in the same cycle the previous one leaves.
         if (w_in_fire) begin
            r_pc         <= pc_i;
            r_inst       <= inst_i;
            r_exu_res    <= exu_res_i;
            r_wb_ctl     <= wb_ctl_i;
            r_rd_addr    <= rd_addr_i;
            r_rd_ena     <= rd_ena_i & ~w_fault;
            r_misalign   <= w_fault;
            r_ls_rd_data <= '0;
            r_funct3     <= w_f3;
            r_is_load    <= w_is_load;
            r_dm_wen     <= w_is_store;
            r_dm_wdata   <= w_wdata;
            r_dm_wstrb   <= w_is_store ? w_wstrb : 4'b0000;
            if (w_go_bus) begin
               r_state     <= S_REQ;
               r_req_valid <= 1'b1;
               r_busy      <= 1'b1;
               r_out_valid <= 1'b0;
            end else begin
               r_state     <= S_DONE;
               r_req_valid <= 1'b0;
               r_busy      <= 1'b0;
               r_out_valid <= 1'b1;
            end
         end
      end
   end

   assign dm_req_valid = r_req_valid;
   assign dm_addr      = {r_exu_res[DATA_W-1:2], 2'b00};
   assign dm_wen       = r_dm_wen;
   assign dm_wdata     = r_dm_wdata;
   assign dm_wstrb     = r_dm_wstrb;
   assign out_valid    = r_out_valid;
   assign pc_o         = r_pc;
   assign inst_o       = r_inst;
   assign exu_res_o    = r_exu_res;
   assign wb_ctl_o     = r_wb_ctl;
   assign rd_ena_o     = r_rd_ena;
   assign rd_addr_o    = r_rd_addr;
   assign ls_rd_data   = r_ls_rd_data;
   assign ls_busy      = r_busy;
   assign ls_misalign  = r_misalign;

endmodule
`default_nettype wire

// File: tb/tb_ysyx_25060170_lsu_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ysyx_25060170_lsu_stage
//  Description : Self-checking bench for the LSU stage. Directed cases plus
//                randomized loads/stores/pass-throughs checked against a
//                byte-level reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_ysyx_25060170_lsu_stage;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] pc_i = '0, inst_i = '0, exu_res_i = '0, st_data_i = '0;
   logic [4:0]  mem_ctl_i = '0;
   logic [1:0]  wb_ctl_i = '0;
   logic        rd_ena_i = 1'b0;
   logic [4:0]  rd_addr_i = '0;
   logic        dm_req_valid;
   logic        dm_req_ready = 1'b0;
   logic [31:0] dm_addr;
   logic        dm_wen;
   logic [31:0] dm_wdata;
   logic [3:0]  dm_wstrb;
   logic        dm_rsp_valid = 1'b0;
   logic [31:0] dm_rdata = '0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] pc_o, inst_o, exu_res_o, ls_rd_data;
   logic [1:0]  wb_ctl_o;
   logic        rd_ena_o;
   logic [4:0]  rd_addr_o;
   logic        ls_busy;
   logic        ls_misalign;

   int checks = 0;
   int errors = 0;

   ysyx_25060170_lsu_stage #(.DATA_W(32)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .pc_i(pc_i), .inst_i(inst_i), .exu_res_i(exu_res_i), .st_data_i(st_data_i),
      .mem_ctl_i(mem_ctl_i), .wb_ctl_i(wb_ctl_i), .rd_ena_i(rd_ena_i), .rd_addr_i(rd_addr_i),
      .dm_req_valid(dm_req_valid), .dm_req_ready(dm_req_ready), .dm_addr(dm_addr),
      .dm_wen(dm_wen), .dm_wdata(dm_wdata), .dm_wstrb(dm_wstrb),
      .dm_rsp_valid(dm_rsp_valid), .dm_rdata(dm_rdata),
      .out_valid(out_valid), .out_ready(out_ready),
      .pc_o(pc_o), .inst_o(inst_o), .exu_res_o(exu_res_o), .wb_ctl_o(wb_ctl_o),
      .rd_ena_o(rd_ena_o), .rd_addr_o(rd_addr_o),
      .ls_rd_data(ls_rd_data), .ls_busy(ls_busy), .ls_misalign(ls_misalign)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic int size_bytes(input logic [2:0] f3);
      case (f3[1:0])
         2'd0:    return 1;
         2'd1:    return 2;
         default: return 4;
      endcase
   endfunction

   function automatic bit f3_legal(input bit is_ld, input logic [2:0] f3);
      if (is_ld) return (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
      return (f3 inside {3'd0, 3'd1, 3'd2});
   endfunction

   function automatic logic [31:0] load_value(input logic [2:0] f3, input logic [31:0] word, input int off);
      longint v;
      v = longint'(word) >> (8 * off);
      case (f3)
         3'd0: begin v = v % 256;   if (v >= 128)   v = v - 256;   end
         3'd1: begin v = v % 65536; if (v >= 32768) v = v - 65536; end
         3'd4: v = v % 256;
         3'd5: v = v % 65536;
         default: v = v % (longint'(1) << 32);
      endcase
      return 32'(v);
   endfunction

   // Drive one instruction, play the memory, and check every cycle until it drains.
   task automatic run_op(input logic [31:0] pc, input logic [31:0] addr, input logic [31:0] sdata,
                         input logic [4:0] mctl, input logic [1:0] wbc, input logic rde,
                         input logic [4:0] rda, input logic [31:0] rdata,
                         input int req_stall, input int rsp_delay, input int ordy_stall,
                         output logic [31:0] got_rd, output logic [3:0] got_wstrb,
                         output logic [31:0] got_wdata);
      bit ld, st, mem, fault, bus;
      int off, nb;
      logic [31:0] exp_rd, exp_wdata, inst;
      logic [3:0]  exp_wstrb;
      ld        = mctl[4] && !mctl[3];
      st        = mctl[3] && !mctl[4];
      mem       = ld || st;
      off       = int'(addr % 4);
      nb        = size_bytes(mctl[2:0]);
      fault     = mem && (!f3_legal(ld, mctl[2:0]) || (off % nb) != 0);
      bus       = mem && !fault;
      exp_rd    = (bus && ld) ? load_value(mctl[2:0], rdata, off) : 32'd0;
      exp_wstrb = 4'(((1 << nb) - 1) << off);
      exp_wdata = 32'(longint'(sdata) << (8 * off));
      inst      = $urandom;
      got_wstrb = '0;
      got_wdata = '0;
      got_rd    = '0;

      chk("in_ready_idle", in_ready, 1);
      in_valid = 1; pc_i = pc; inst_i = inst; exu_res_i = addr; st_data_i = sdata;
      mem_ctl_i = mctl; wb_ctl_i = wbc; rd_ena_i = rde; rd_addr_i = rda;
      @(negedge clk);
      in_valid = 0;
      pc_i = $urandom; exu_res_i = $urandom; st_data_i = $urandom;

      if (bus) begin
         for (int i = 0; i <= req_stall; i++) begin
            chk("req_valid", dm_req_valid, 1);
            chk("req_busy", ls_busy, 1);
            chk("req_out_valid", out_valid, 0);
            chk("req_addr", dm_addr, {addr[31:2], 2'b00});
            chk("req_wen", dm_wen, st);
            if (st) begin
               chk("req_wstrb", dm_wstrb, exp_wstrb);
               chk("req_wdata", dm_wdata, exp_wdata);
            end
            got_wstrb = dm_wstrb;
            got_wdata = dm_wdata;
            dm_req_ready = (i == req_stall);
            dm_rsp_valid = 1'($urandom_range(0, 1));
            dm_rdata     = $urandom;
            @(negedge clk);
         end
         dm_req_ready = 0;
         dm_rsp_valid = 0;
         for (int i = 0; i <= rsp_delay; i++) begin
            chk("wait_req_low", dm_req_valid, 0);
            chk("wait_busy", ls_busy, 1);
            chk("wait_out_valid", out_valid, 0);
            dm_rsp_valid = (i == rsp_delay);
            dm_rdata     = (i == rsp_delay) ? rdata : $urandom;
            @(negedge clk);
         end
         dm_rsp_valid = 0;
         dm_rdata     = $urandom;
      end else begin
         chk("nobus_req", dm_req_valid, 0);
      end

      for (int i = 0; i <= ordy_stall; i++) begin
         chk("out_valid", out_valid, 1);
         chk("out_pc", pc_o, pc);
         chk("out_inst", inst_o, inst);
         chk("out_exu_res", exu_res_o, addr);
         chk("out_wb_ctl", wb_ctl_o, wbc);
         chk("out_rd_ena", rd_ena_o, rde && !fault);
         chk("out_rd_addr", rd_addr_o, rda);
         chk("out_ls_rd_data", ls_rd_data, exp_rd);
         chk("out_misalign", ls_misalign, fault);
         chk("out_busy", ls_busy, 0);
         chk("out_req_low", dm_req_valid, 0);
         got_rd    = ls_rd_data;
         out_ready = (i == ordy_stall);
         @(negedge clk);
      end
      out_ready = 0;
      chk("drained", out_valid, 0);
   endtask

   initial begin
      logic [31:0] g_rd, g_wd;
      logic [3:0]  g_ws;
      logic [31:0] pcs [0:7];
      logic [31:0] ress[0:7];
      logic [4:0]  mc;
      int kind;

      // ---- reset state ----
      repeat (2) @(negedge clk);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_req_valid", dm_req_valid, 0);
      chk("rst_busy", ls_busy, 0);
      chk("rst_misalign", ls_misalign, 0);
      chk("rst_pc", pc_o, 0);
      chk("rst_rd_data", ls_rd_data, 0);
      rst = 1;
      @(negedge clk);

      // ---- LW zero-wait ----
      run_op(32'h100, 32'h8000_0104, 32'h0, 5'b10_010, 2'b01, 1, 5'd5, 32'hDEAD_BEEF, 0, 0, 0, g_rd, g_ws, g_wd);
      chk("lw_data", g_rd, 32'hDEAD_BEEF);
      // ---- LB / LBU top byte ----
      run_op(32'h104, 32'h8000_0103, 32'h0, 5'b10_000, 2'b01, 1, 5'd6, 32'h80FF_00AA, 0, 0, 0, g_rd, g_ws, g_wd);
      chk("lb_data", g_rd, 32'hFFFF_FF80);
      run_op(32'h108, 32'h8000_0103, 32'h0, 5'b10_100, 2'b01, 1, 5'd7, 32'h80FF_00AA, 1, 2, 0, g_rd, g_ws, g_wd);
      chk("lbu_data", g_rd, 32'h0000_0080);
      // ---- SH upper half ----
      run_op(32'h10C, 32'h8000_0102, 32'h0000_1234, 5'b01_001, 2'b00, 0, 5'd0, 32'h0, 0, 0, 0, g_rd, g_ws, g_wd);
      chk("sh_wstrb", g_ws, 4'b1100);
      chk("sh_wdata", g_wd, 32'h1234_0000);
      // ---- misaligned LW ----
      run_op(32'h110, 32'h8000_0106, 32'h0, 5'b10_010, 2'b01, 1, 5'd8, 32'h1111_1111, 0, 0, 0, g_rd, g_ws, g_wd);
      chk("mis_rd_data", g_rd, 0);
      // ---- request stalled 5 cycles, output stalled 3 cycles ----
      run_op(32'h114, 32'h8000_0200, 32'hCAFE_F00D, 5'b01_010, 2'b00, 0, 5'd0, 32'h0, 5, 1, 3, g_rd, g_ws, g_wd);
      chk("sw_wstrb", g_ws, 4'b1111);

      // ---- back-to-back pass-through ADDs ----
      out_ready = 1;
      for (int k = 0; k < 8; k++) begin
         if (k > 0) begin
            chk("b2b_valid", out_valid, 1);
            chk("b2b_pc", pc_o, pcs[k-1]);
            chk("b2b_res", exu_res_o, ress[k-1]);
            chk("b2b_rd_ena", rd_ena_o, 1);
            chk("b2b_busy", ls_busy, 0);
            chk("b2b_in_ready", in_ready, 1);
         end
         pcs[k] = 32'h2000 + 32'(4 * k);
         ress[k] = $urandom;
         in_valid = 1; pc_i = pcs[k]; exu_res_i = ress[k]; mem_ctl_i = 5'b00_000;
         wb_ctl_i = 2'b10; rd_ena_i = 1; rd_addr_i = 5'(k + 1);
         @(negedge clk);
      end
      in_valid = 0;
      chk("b2b_last_valid", out_valid, 1);
      chk("b2b_last_pc", pc_o, pcs[7]);
      @(negedge clk);
      chk("b2b_drain", out_valid, 0);
      out_ready = 0;

      // ---- reset while waiting for a response; late response dropped ----
      in_valid = 1; pc_i = 32'h300; exu_res_i = 32'h8000_0400; mem_ctl_i = 5'b10_010;
      wb_ctl_i = 2'b01; rd_ena_i = 1; rd_addr_i = 5'd9;
      @(negedge clk);
      in_valid = 0; dm_req_ready = 1;
      @(negedge clk);
      dm_req_ready = 0;
      chk("rstw_busy", ls_busy, 1);
      chk("rstw_req_low", dm_req_valid, 0);
      rst = 0;
      #1;
      chk("rstw_busy_clr", ls_busy, 0);
      chk("rstw_out_valid", out_valid, 0);
      chk("rstw_pc", pc_o, 0);
      chk("rstw_in_ready", in_ready, 1);
      @(negedge clk);
      rst = 1; dm_rsp_valid = 1; dm_rdata = 32'h5A5A_5A5A;
      @(negedge clk);
      dm_rsp_valid = 0;
      chk("rstw_late_rsp", out_valid, 0);
      chk("rstw_late_busy", ls_busy, 0);
      chk("rstw_late_data", ls_rd_data, 0);
      @(negedge clk);

      // ---- randomized mix ----
      for (int n = 0; n < 80; n++) begin
         kind = int'($urandom_range(0, 3));
         mc[2:0] = 3'($urandom_range(0, 7));
         case (kind)
            0:       mc[4:3] = 2'b10;
            1:       mc[4:3] = 2'b01;
            2:       mc[4:3] = 2'b00;
            default: mc[4:3] = 2'b11;
         endcase
         run_op($urandom, {16'h8000, 16'($urandom)}, $urandom, mc, 2'($urandom_range(0, 2)),
                1'($urandom_range(0, 1)), 5'($urandom), $urandom,
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 2)),
                g_rd, g_ws, g_wd);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
